sgpr_3to1_wr_port_arb: RTL and testbench
========================================

SGPR_3TO1_WR_PORT_ARB -- requirements
Module: sgpr_3to1_wr_port_arb

Interface
REQ-001 Parameter: ADDR_W, 9, SGPR write address width.
REQ-002 Parameter: DATA_W, 128, SGPR write data width (four 32-bit lanes).
REQ-003 Parameter: EN_W, 4, per-lane write enable width.
REQ-004 One clock and one reset: reset is asynchronous and active-low (ports clk and rst_n).
REQ-005 clk  input  1  block clock, all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 portN_wr_en  input  EN_W  per-lane enable for writer N (N = 0,1,2); nonzero means request.
REQ-008 portN_wr_addr  input  ADDR_W  write address for writer N.
REQ-009 portN_wr_data  input  DATA_W  write data for writer N.
REQ-010 portN_ready  output  1  writer N holding slot empty; a request is accepted when ready=1.
REQ-011 wr_en  output  EN_W  per-lane enable to SGPR write port, registered.
REQ-012 wr_addr  output  ADDR_W  address to SGPR write port, registered.
REQ-013 wr_data  output  DATA_W  data to SGPR write port, registered.
REQ-014 busy  output  1  high while any slot or the output register holds a valid write.

Function
REQ-015 Each port SHALL own a one-entry holding slot (valid, en, addr, data).
REQ-016 portN_ready SHALL equal NOT slotN.valid (combinational from state only, no input paths).
REQ-017 On an edge where portN_wr_en != 0 and portN_ready = 1, the slot SHALL capture en/addr/data and set valid.
REQ-018 A request with portN_ready = 0 SHALL be ignored; writer holds it until ready; wr_en = 0 is never captured.
REQ-019 Each cycle with at least one valid slot, a round-robin arbiter SHALL grant exactly one slot, searching from the port after the last granted.
REQ-020 The granted slot SHALL be loaded into wr_en/wr_addr/wr_data on the next edge and its valid cleared on that same edge.
REQ-021 Latency: request accepted at edge k appears on wr_* after edge k+1 when uncontended (one cycle in slot, one in output register).
REQ-022 Cycles with no valid slot SHALL drive wr_en = 0; wr_addr/wr_data hold their last values.
REQ-023 Aggregate throughput SHALL be one write per cycle; per-port throughput one write per two cycles.
REQ-024 Writes to the same address from different ports SHALL be issued separately in grant order; no merging of lanes.
REQ-025 Round-robin pointer SHALL update only on a grant; after reset port 0 has highest priority, then 1, then 2.
REQ-026 busy = slot0.valid | slot1.valid | slot2.valid | (wr_en != 0).

Reset
REQ-027 While rst_n = 0: all slot valids 0, wr_en = 0, wr_addr = 0, wr_data = 0, pointer = port 0, all portN_ready = 1.
REQ-028 Reset asserted mid-operation SHALL discard all held and in-flight writes without issuing them.
REQ-029 Reset deassertion SHALL be synchronized by the integrator; first accept possible on first edge after release.

Structure
REQ-030 Package sgpr_wr_pkg SHALL hold ADDR_W/DATA_W/EN_W defaults and the slot record type.
REQ-031 Sub-module rr_arb3 (3-request round-robin arbiter: req[2:0], grant one-hot, pointer state) SHALL be instantiated once.
REQ-032 Slots and output register SHALL reside in the top module; no other sub-modules.

Verification
REQ-033 Single write: after reset, port1 en=4'hF addr=9'h010 data=A for one cycle -> wr_en=4'hF addr=9'h010 data=A two edges later, port1_ready low exactly one cycle.
REQ-034 Triple collision: all ports request same cycle after reset -> issue order port0, port1, port2 on three consecutive cycles, busy falls after last.
REQ-035 Fairness: ports 0 and 2 request continuously -> grants alternate 0,2,0,2; neither starved.
REQ-036 Backpressure: port0 holds request while ready=0 -> captured exactly once per ready window; no duplicate or lost writes (scoreboard count match over 1000 random cycles).
REQ-037 Partial lanes/same address: port0 en=4'h1, port2 en=4'h8, both addr 9'h1FF -> two separate writes with unmerged enables.
REQ-038 Reset mid-flight: assert rst_n=0 with all slots full -> wr_en=0 immediately, ready=1 for all ports, no stale write after release.

Source files
------------

// File: rtl/sgpr_wr_pkg.sv
// Shared widths, the holding-slot record and the round-robin pointer encoding
// for the three-writer SGPR write port arbiter.
package sgpr_wr_pkg;

    localparam int SGPR_ADDR_W = 9;
    localparam int SGPR_DATA_W = 128;
    localparam int SGPR_EN_W   = 4;
    localparam int NUM_PORTS   = 3;

    // One writer's holding slot: a single pending write plus its valid flag.
    typedef struct packed {
        logic                   valid;
        logic [SGPR_EN_W-1:0]   en;
        logic [SGPR_ADDR_W-1:0] addr;
        logic [SGPR_DATA_W-1:0] data;
    } slot_t;

    // Round-robin pointer: the port that gets first look on the next grant.
    typedef enum logic [1:0] {
        PTR_P0 = 2'd0,
        PTR_P1 = 2'd1,
        PTR_P2 = 2'd2
    } rr_ptr_e;

    // Pointer value that follows a one-hot grant (the port after the winner).
    function automatic rr_ptr_e ptr_after(input logic [2:0] grant, input rr_ptr_e cur);
        rr_ptr_e nxt;
        nxt = cur;
        if (grant[0]) nxt = PTR_P1;
        if (grant[1]) nxt = PTR_P2;
        if (grant[2]) nxt = PTR_P0;
        return nxt;
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-request round-robin arbiter. Grant is one-hot and combinational from
// the request vector and the stored pointer; the pointer advances to the port
// after the winner, and only on cycles that actually grant.
//
// state  | meaning
// PTR_P0 | port 0 searched first (reset value)
// PTR_P1 | port 1 searched first
// PTR_P2 | port 2 searched first
module rr_arb3
    import sgpr_wr_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    output logic [2:0] grant
);

    rr_ptr_e ptr_q;
    rr_ptr_e ptr_d;

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PTR_P0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Priority search starting at the pointer, then next-pointer from the winner.
    always_comb begin
        grant = 3'b000;
        case (ptr_q)
            PTR_P1: begin
                if      (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            PTR_P2: begin
                if      (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
            default: begin
                if      (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
        endcase
        ptr_d = ptr_after(grant, ptr_q);
    end

endmodule

// File: rtl/sgpr_3to1_wr_port_arb.sv
// Merges three SGPR writers onto one registered write port. Each writer owns
// a one-entry holding slot; ready is simply "slot empty", so a writer can
// issue at most every other cycle while the shared port sustains one write
// per cycle. Writes are never merged, even to the same address.
module sgpr_3to1_wr_port_arb
    import sgpr_wr_pkg::*;
#(
    parameter int ADDR_W = SGPR_ADDR_W,
    parameter int DATA_W = SGPR_DATA_W,
    parameter int EN_W   = SGPR_EN_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [EN_W-1:0]   port0_wr_en,
    input  logic [ADDR_W-1:0] port0_wr_addr,
    input  logic [DATA_W-1:0] port0_wr_data,
    output logic              port0_ready,

    input  logic [EN_W-1:0]   port1_wr_en,
    input  logic [ADDR_W-1:0] port1_wr_addr,
    input  logic [DATA_W-1:0] port1_wr_data,
    output logic              port1_ready,

    input  logic [EN_W-1:0]   port2_wr_en,
    input  logic [ADDR_W-1:0] port2_wr_addr,
    input  logic [DATA_W-1:0] port2_wr_data,
    output logic              port2_ready,

    output logic [EN_W-1:0]   wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy
);

    logic [EN_W-1:0]   in_en   [NUM_PORTS];
    logic [ADDR_W-1:0] in_addr [NUM_PORTS];
    logic [DATA_W-1:0] in_data [NUM_PORTS];

    logic [NUM_PORTS-1:0] slot_valid;
    logic [EN_W-1:0]      slot_en   [NUM_PORTS];
    logic [ADDR_W-1:0]    slot_addr [NUM_PORTS];
    logic [DATA_W-1:0]    slot_data [NUM_PORTS];

    logic [NUM_PORTS-1:0] grant;
    logic [EN_W-1:0]      sel_en;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_data;

    assign in_en[0]   = port0_wr_en;
    assign in_addr[0] = port0_wr_addr;
    assign in_data[0] = port0_wr_data;
    assign in_en[1]   = port1_wr_en;
    assign in_addr[1] = port1_wr_addr;
    assign in_data[1] = port1_wr_data;
    assign in_en[2]   = port2_wr_en;
    assign in_addr[2] = port2_wr_addr;
    assign in_data[2] = port2_wr_data;

    // Ready depends on slot state only, so there is no input-to-ready path.
    assign port0_ready = ~slot_valid[0];
    assign port1_ready = ~slot_valid[1];
    assign port2_ready = ~slot_valid[2];

    rr_arb3 u_rr_arb3 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (slot_valid),
        .grant (grant)
    );

    // Holding slots: an empty slot captures a nonzero-enable request; a full
    // slot ignores its input and empties on the edge it is granted. Because a
    // granted slot is still full that cycle, it cannot refill on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                slot_en[i]   <= '0;
                slot_addr[i] <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (slot_valid[i]) begin
                    if (grant[i]) begin
                        slot_valid[i] <= 1'b0;
                    end
                end else if (|in_en[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot_en[i]    <= in_en[i];
                    slot_addr[i]  <= in_addr[i];
                    slot_data[i]  <= in_data[i];
                end
            end
        end
    end

    // One-hot select of the granted slot's payload.
    always_comb begin
        sel_en   = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                sel_en   = slot_en[i];
                sel_addr = slot_addr[i];
                sel_data = slot_data[i];
            end
        end
    end

    // Output register: idle cycles drop the enable but keep address/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (|grant) begin
            wr_en   <= sel_en;
            wr_addr <= sel_addr;
            wr_data <= sel_data;
        end else begin
            wr_en   <= '0;
        end
    end

    assign busy = (|slot_valid) | (|wr_en);

endmodule

// File: tb/tb_sgpr_3to1_wr_port_arb.sv
// Directed vector table plus hand-written sequences for collision order,
// fairness, random backpressure with a scoreboard, and mid-flight reset.
module tb_sgpr_3to1_wr_port_arb;

    logic         clk;
    logic         rst_n;
    logic [3:0]   port0_wr_en,   port1_wr_en,   port2_wr_en;
    logic [8:0]   port0_wr_addr, port1_wr_addr, port2_wr_addr;
    logic [127:0] port0_wr_data, port1_wr_data, port2_wr_data;
    logic         port0_ready,   port1_ready,   port2_ready;
    logic [3:0]   wr_en;
    logic [8:0]   wr_addr;
    logic [127:0] wr_data;
    logic         busy;

    int errors = 0;
    int checks = 0;

    sgpr_3to1_wr_port_arb dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .port0_wr_en   (port0_wr_en),
        .port0_wr_addr (port0_wr_addr),
        .port0_wr_data (port0_wr_data),
        .port0_ready   (port0_ready),
        .port1_wr_en   (port1_wr_en),
        .port1_wr_addr (port1_wr_addr),
        .port1_wr_data (port1_wr_data),
        .port1_ready   (port1_ready),
        .port2_wr_en   (port2_wr_en),
        .port2_wr_addr (port2_wr_addr),
        .port2_wr_data (port2_wr_data),
        .port2_ready   (port2_ready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  e0, e1, e2;
        logic [8:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic [3:0]  x_en;
        logic [8:0]  x_addr;
        logic [31:0] x_data;
        logic [2:0]  x_rdy;
        logic        x_busy;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [31:0] q2 [$];
    int iss_cnt;

    function automatic logic [127:0] dw(input logic [31:0] w);
        return {4{w}};
    endfunction

    function automatic vec_t mk(
        input logic [3:0] e0, input logic [8:0] a0, input logic [31:0] d0,
        input logic [3:0] e1, input logic [8:0] a1, input logic [31:0] d1,
        input logic [3:0] e2, input logic [8:0] a2, input logic [31:0] d2,
        input logic [3:0] xe, input logic [8:0] xa, input logic [31:0] xd,
        input logic [2:0] xr, input logic xb);
        vec_t v;
        v.e0 = e0; v.a0 = a0; v.d0 = d0;
        v.e1 = e1; v.a1 = a1; v.d1 = d1;
        v.e2 = e2; v.a2 = a2; v.d2 = d2;
        v.x_en = xe; v.x_addr = xa; v.x_data = xd; v.x_rdy = xr; v.x_busy = xb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [3:0] e, input logic [8:0] a, input logic [127:0] d);
        case (p)
            0: begin port0_wr_en = e; port0_wr_addr = a; port0_wr_data = d; end
            1: begin port1_wr_en = e; port1_wr_addr = a; port1_wr_data = d; end
            default: begin port2_wr_en = e; port2_wr_addr = a; port2_wr_data = d; end
        endcase
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < 3; p++) set_port(p, 4'h0, 9'h0, 128'h0);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Per-port in-order scoreboard for the random section.
    task automatic sb_check();
        logic [31:0] tag;
        logic [31:0] exp;
        int p;
        if (wr_en != 4'h0) begin
            tag = wr_data[31:0];
            p = int'(tag[31:30]);
            exp = 32'hDEAD_BEEF;
            iss_cnt++;
            case (p)
                0: if (q0.size() > 0) exp = q0.pop_front();
                1: if (q1.size() > 0) exp = q1.pop_front();
                2: if (q2.size() > 0) exp = q2.pop_front();
                default: ;
            endcase
            chk("sb_data", wr_data, dw(exp));
            chk("sb_en", 128'(wr_en), 128'(exp[29:26]));
            chk("sb_addr", 128'(wr_addr), 128'(exp[8:0]));
        end
    endtask

    initial begin
        vec_t v;
        logic [31:0] tag [3];
        logic [2:0]  pend;
        logic [2:0]  rdy;
        logic [2:0]  acc;
        logic [25:0] seq;
        logic [1:0]  exp_port;
        int          acc_cnt;
        int          fair_iss;

        //           e0    a0      d0            e1    a1      d1            e2    a2      d2            x_en  x_addr  x_data        rdy     busy
        vecs[0]  = mk(4'h0, 9'h000, 32'h0,        4'hF, 9'h010, 32'hA1A1_0001, 4'h0, 9'h000, 32'h0,        4'h0, 9'h000, 32'h0,         3'b101, 1'b1);
        vecs[1]  = mk(4'h0, 9'h000, 32'h0,        4'h0, 9'h000, 32'h0,         4'h0, 9'h000, 32'h0,        4'hF, 9'h010, 32'hA1A1_0001, 3'b111, 1'b1);
        vecs[2]  = mk(4'h0, 9'h000, 32'h0,        4'h0, 9'h000, 32'h0,         4'h0, 9'h000, 32'h0,        4'h0, 9'h010, 32'hA1A1_0001, 3'b111, 1'b0);
        vecs[3]  = mk(4'h3, 9'h020, 32'hB0B0_0000, 4'hC, 9'h021, 32'hB1B1_0001, 4'hF, 9'h022, 32'hB2B2_0002, 4'h0, 9'h010, 32'hA1A1_0001, 3'b000, 1'b1);
        vecs[4]  = mk(4'h0, 9'h000, 32'h0,        4'h0, 9'h000, 32'h0,         4'h0, 9'h000, 32'h0,        4'hF, 9'h022, 32'hB2B2_0002, 3'b100, 1'b1);
        vecs[5]  = mk(4'h0, 9'h000, 32'h0,        4'h0, 9'h000, 32'h0,         4'h0, 9'h000, 32'h0,        4'h3, 9'h020, 32'hB0B0_0000, 3'b101, 1'b1);
        vecs[6]  = mk(4'h0, 9'h000, 32'h0,        4'h0, 9'h000, 32'h0,         4'h0, 9'h000, 32'h0,        4'hC, 9'h021, 32'hB1B1_0001, 3'b111, 1'b1);
        vecs[7]  = mk(4'h0, 9'h000, 32'h0,        4'h0, 9'h000, 32'h0,         4'h0, 9'h000, 32'h0,        4'h0, 9'h021, 32'hB1B1_0001, 3'b111, 1'b0);
        vecs[8]  = mk(4'h1, 9'h1FF, 32'hC0C0_0000, 4'h0, 9'h000, 32'h0,         4'h8, 9'h1FF, 32'hC2C2_0002, 4'h0, 9'h021, 32'hB1B1_0001, 3'b010, 1'b1);
        vecs[9]  = mk(4'h0, 9'h000, 32'h0,        4'h0, 9'h000, 32'h0,         4'h0, 9'h000, 32'h0,        4'h8, 9'h1FF, 32'hC2C2_0002, 3'b110, 1'b1);
        vecs[10] = mk(4'h0, 9'h000, 32'h0,        4'h0, 9'h000, 32'h0,         4'h0, 9'h000, 32'h0,        4'h1, 9'h1FF, 32'hC0C0_0000, 3'b111, 1'b1);
        vecs[11] = mk(4'h0, 9'h000, 32'h0,        4'h0, 9'h000, 32'h0,         4'h0, 9'h000, 32'h0,        4'h0, 9'h1FF, 32'hC0C0_0000, 3'b111, 1'b0);
        vecs[12] = mk(4'h0, 9'h055, 32'hD0D0_0000, 4'h0, 9'h000, 32'h0,         4'h0, 9'h000, 32'h0,        4'h0, 9'h1FF, 32'hC0C0_0000, 3'b111, 1'b0);
        vecs[13] = mk(4'hF, 9'h030, 32'hE0E0_0000, 4'h0, 9'h000, 32'h0,         4'h0, 9'h000, 32'h0,        4'h0, 9'h1FF, 32'hC0C0_0000, 3'b110, 1'b1);
        vecs[14] = mk(4'hF, 9'h031, 32'hE1E1_0001, 4'h0, 9'h000, 32'h0,         4'h0, 9'h000, 32'h0,        4'hF, 9'h030, 32'hE0E0_0000, 3'b111, 1'b1);
        vecs[15] = mk(4'hF, 9'h031, 32'hE1E1_0001, 4'h0, 9'h000, 32'h0,         4'h0, 9'h000, 32'h0,        4'h0, 9'h030, 32'hE0E0_0000, 3'b110, 1'b1);
        vecs[16] = mk(4'h0, 9'h000, 32'h0,        4'h0, 9'h000, 32'h0,         4'h0, 9'h000, 32'h0,        4'hF, 9'h031, 32'hE1E1_0001, 3'b111, 1'b1);
        vecs[17] = mk(4'h0, 9'h000, 32'h0,        4'h0, 9'h000, 32'h0,         4'h0, 9'h000, 32'h0,        4'h0, 9'h031, 32'hE1E1_0001, 3'b111, 1'b0);

        // Reset state, with a request presented during reset that must not stick.
        clear_inputs();
        rst_n = 1'b0;
        #1;
        set_port(0, 4'hF, 9'h123, dw(32'h1234_5678));
        tick();
        tick();
        chk("rst_wr_en", 128'(wr_en), 128'h0);
        chk("rst_wr_addr", 128'(wr_addr), 128'h0);
        chk("rst_wr_data", wr_data, 128'h0);
        chk("rst_ready", 128'({port2_ready, port1_ready, port0_ready}), 128'(3'b111));
        chk("rst_busy", 128'(busy), 128'h0);
        clear_inputs();
        rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < NVEC; i++) begin
            set_port(0, vecs[i].e0, vecs[i].a0, dw(vecs[i].d0));
            set_port(1, vecs[i].e1, vecs[i].a1, dw(vecs[i].d1));
            set_port(2, vecs[i].e2, vecs[i].a2, dw(vecs[i].d2));
            tick();
            chk($sformatf("vec%0d_wr_en", i), 128'(wr_en), 128'(vecs[i].x_en));
            chk($sformatf("vec%0d_wr_addr", i), 128'(wr_addr), 128'(vecs[i].x_addr));
            chk($sformatf("vec%0d_wr_data", i), wr_data, dw(vecs[i].x_data));
            chk($sformatf("vec%0d_ready", i), 128'({port2_ready, port1_ready, port0_ready}), 128'(vecs[i].x_rdy));
            chk($sformatf("vec%0d_busy", i), 128'(busy), 128'(vecs[i].x_busy));
        end
        clear_inputs();

        // Triple collision straight after reset: issue order 0,1,2.
        do_reset();
        set_port(0, 4'h1, 9'h100, dw(32'h0000_0100));
        set_port(1, 4'h2, 9'h101, dw(32'h0000_0101));
        set_port(2, 4'h4, 9'h102, dw(32'h0000_0102));
        tick();
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("tri%0d_addr", k), 128'(wr_addr), 128'(9'h100 + 9'(k)));
            chk($sformatf("tri%0d_en", k), 128'(wr_en), 128'(4'h1 << k));
            chk($sformatf("tri%0d_busy", k), 128'(busy), 128'h1);
        end
        tick();
        chk("tri_done_en", 128'(wr_en), 128'h0);
        chk("tri_done_busy", 128'(busy), 128'h0);

        // Fairness: ports 0 and 2 request continuously.
        do_reset();
        seq = 26'd0;
        fair_iss = 0;
        exp_port = 2'd0;
        for (int p = 0; p < 3; p += 2) begin
            tag[p] = {2'(p), 4'hF, seq};
            seq++;
            set_port(p, tag[p][29:26], tag[p][8:0], dw(tag[p]));
        end
        for (int c = 0; c < 20; c++) begin
            rdy = {port2_ready, port1_ready, port0_ready};
            tick();
            if (wr_en != 4'h0) begin
                fair_iss++;
                chk("fair_port", 128'(wr_data[31:30]), 128'(exp_port));
                exp_port = (exp_port == 2'd0) ? 2'd2 : 2'd0;
            end
            for (int p = 0; p < 3; p += 2) begin
                if (rdy[p]) begin
                    tag[p] = {2'(p), 4'hF, seq};
                    seq++;
                    set_port(p, tag[p][29:26], tag[p][8:0], dw(tag[p]));
                end
            end
        end
        chk("fair_count", 128'(fair_iss), 128'd19);
        clear_inputs();

        // Random backpressure: writers hold requests until ready, scoreboard per port.
        do_reset();
        pend = 3'b000;
        acc_cnt = 0;
        iss_cnt = 0;
        seq = 26'd100;
        for (int c = 0; c < 1000; c++) begin
            for (int p = 0; p < 3; p++) begin
                if (!pend[p] && ($urandom_range(0, 2) != 0)) begin
                    tag[p] = {2'(p), 4'($urandom_range(1, 15)), seq};
                    seq++;
                    pend[p] = 1'b1;
                    set_port(p, tag[p][29:26], tag[p][8:0], dw(tag[p]));
                end
            end
            rdy = {port2_ready, port1_ready, port0_ready};
            acc = 3'b000;
            for (int p = 0; p < 3; p++) begin
                if (pend[p] && rdy[p]) begin
                    acc[p] = 1'b1;
                    acc_cnt++;
                    case (p)
                        0: q0.push_back(tag[p]);
                        1: q1.push_back(tag[p]);
                        default: q2.push_back(tag[p]);
                    endcase
                end
            end
            tick();
            sb_check();
            for (int p = 0; p < 3; p++) begin
                if (acc[p]) begin
                    pend[p] = 1'b0;
                    set_port(p, 4'h0, 9'h0, 128'h0);
                end
            end
        end
        clear_inputs();
        for (int c = 0; c < 6; c++) begin
            tick();
            sb_check();
        end
        chk("sb_count", 128'(iss_cnt), 128'(acc_cnt));
        chk("sb_left", 128'(q0.size() + q1.size() + q2.size()), 128'd0);
        chk("sb_idle_busy", 128'(busy), 128'h0);

        // Reset mid-flight with all slots full and an output in flight.
        do_reset();
        set_port(0, 4'hF, 9'h0A0, dw(32'hF0F0_0000));
        set_port(1, 4'hF, 9'h0A1, dw(32'hF1F1_0001));
        set_port(2, 4'hF, 9'h0A2, dw(32'hF2F2_0002));
        tick();
        chk("mid_full_ready", 128'({port2_ready, port1_ready, port0_ready}), 128'(3'b000));
        tick();
        chk("mid_inflight_en", 128'(wr_en), 128'hF);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", 128'(wr_en), 128'h0);
        chk("mid_rst_addr", 128'(wr_addr), 128'h0);
        chk("mid_rst_ready", 128'({port2_ready, port1_ready, port0_ready}), 128'(3'b111));
        chk("mid_rst_busy", 128'(busy), 128'h0);
        clear_inputs();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("mid_post%0d_en", c), 128'(wr_en), 128'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
